// File: rtl/s5_div_sched.sv
// s5_div_sched: computes z = (a % b == zero) ? c / d : a / b by running the
// a/b and c/d divisions back to back on one shared restoring divider that
// works on unsigned magnitudes. Signs are reapplied in the FIX states.
module s5_div_sched #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] d,
  input  logic [DATAWIDTH-1:0] zero,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] z,
  output logic                 dz
);

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0]  ZERO_W    = '0;
  localparam logic [W-1:0]  ONES_W    = '1;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DIV_AB = 3'd1,
    FIX_AB = 3'd2,
    DIV_CD = 3'd3,
    FIX_CD = 3'd4,
    SEL    = 3'd5
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] step_reg;

  // Latched operands
  logic [W-1:0] a_reg, b_reg, c_reg, d_reg, zero_reg;
  // Signed partial results: e = a/b, g = a%b, f = c/d
  logic [W-1:0] e_reg, g_reg, f_reg;
  // Divider datapath: quotient/dividend shift register, partial remainder, divisor
  logic [W-1:0] quo_reg, rem_reg, dvs_reg;

  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         take;
  logic [W-1:0] rem_next, quo_next;

  // Magnitude of a two's complement value; the most negative value maps to
  // unsigned 2^(W-1), which still fits in W bits.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (ZERO_W - x) : x;
  endfunction

  // Signed quotient from the unsigned one; a zero divisor yields -1.
  function automatic logic [W-1:0] fix_quot(input logic [W-1:0] q,
                                            input logic n_neg,
                                            input logic d_neg,
                                            input logic d_zero);
    if (d_zero) return ONES_W;
    return (n_neg ^ d_neg) ? (ZERO_W - q) : q;
  endfunction

  // Remainder takes the sign of the dividend (also gives rem = dividend for d=0).
  function automatic logic [W-1:0] fix_rem(input logic [W-1:0] r, input logic n_neg);
    return n_neg ? (ZERO_W - r) : r;
  endfunction

  // One restoring shift-subtract step of the shared divider
  always_comb begin
    shifted  = {rem_reg, quo_reg[W-1]};
    diff     = shifted[W-1:0] - dvs_reg;
    take     = (shifted >= {1'b0, dvs_reg});
    rem_next = take ? diff : shifted[W-1:0];
    quo_next = {quo_reg[W-2:0], take};
  end

  // Sequencing FSM with registered outputs and divider state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      z         <= '0;
      dz        <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
      zero_reg  <= '0;
      e_reg     <= '0;
      g_reg     <= '0;
      f_reg     <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          // busy is still high in the done cycle, so a start there is dropped
          if (start && !busy) begin
            a_reg     <= a;
            b_reg     <= b;
            c_reg     <= c;
            d_reg     <= d;
            zero_reg  <= zero;
            quo_reg   <= mag(a);
            rem_reg   <= '0;
            dvs_reg   <= mag(b);
            step_reg  <= '0;
            busy      <= 1'b1;
            state_reg <= DIV_AB;
          end else begin
            busy <= 1'b0;
          end
        end
        DIV_AB, DIV_CD: begin
          quo_reg <= quo_next;
          rem_reg <= rem_next;
          if (step_reg == LAST_STEP) begin
            step_reg  <= '0;
            state_reg <= (state_reg == DIV_AB) ? FIX_AB : FIX_CD;
          end else begin
            step_reg <= step_reg + ONE_C;
          end
        end
        FIX_AB: begin
          e_reg     <= fix_quot(quo_reg, a_reg[W-1], b_reg[W-1], b_reg == ZERO_W);
          g_reg     <= fix_rem(rem_reg, a_reg[W-1]);
          quo_reg   <= mag(c_reg);
          rem_reg   <= '0;
          dvs_reg   <= mag(d_reg);
          state_reg <= DIV_CD;
        end
        FIX_CD: begin
          f_reg     <= fix_quot(quo_reg, c_reg[W-1], d_reg[W-1], d_reg == ZERO_W);
          state_reg <= SEL;
        end
        SEL: begin
          z         <= (g_reg == zero_reg) ? f_reg : e_reg;
          dz        <= (b_reg == ZERO_W) | (d_reg == ZERO_W);
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s5_div_sched.sv
// Testbench for s5_div_sched: directed vector table, hand-written protocol
// sequences and randomized operations against a plain-arithmetic model.
module tb_s5_div_sched;

  localparam int W   = 64;
  localparam int LAT = 2 * W + 4;
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic signed [W-1:0] a = '0, b = '0, c = '0, d = '0, zero = '0;
  logic busy, done, dz;
  logic signed [W-1:0] z;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  s5_div_sched #(.DATAWIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .d(d), .zero(zero),
    .busy(busy), .done(done), .z(z), .dz(dz)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: signed division truncating toward zero, with the d=0 and
  // overflow rules taken straight from the operation rules.
  function automatic void ref_div(input longint x, input longint y,
                                  output longint q, output longint r);
    if (y == 0) begin q = -1; r = x; end
    else if (x == longint'(MINV) && y == -1) begin q = longint'(MINV); r = 0; end
    else begin q = x / y; r = x % y; end
  endfunction

  function automatic longint ref_z(input longint xa, input longint xb, input longint xc,
                                   input longint xd, input longint xz);
    longint e, g, f, unused_r;
    ref_div(xa, xb, e, g);
    ref_div(xc, xd, f, unused_r);
    return (g == xz) ? f : e;
  endfunction

  task automatic scramble_inputs();
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    d = {$urandom, $urandom}; zero = {$urandom, $urandom};
  endtask

  // Start one operation from idle, scramble inputs after acceptance, wait for done.
  task automatic run_op(input logic signed [W-1:0] ia, input logic signed [W-1:0] ib,
                        input logic signed [W-1:0] ic, input logic signed [W-1:0] id,
                        input logic signed [W-1:0] iz,
                        output logic signed [W-1:0] oz, output logic odz,
                        output int lat, output int bcnt);
    @(negedge clk);
    a = ia; b = ib; c = ic; d = id; zero = iz; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    lat = 0; bcnt = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin lat = k; break; end
    end
    oz = z; odz = dz;
  endtask

  typedef struct {
    logic signed [W-1:0] a, b, c, d, zero, z;
    logic dz;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic signed [W-1:0] rz, ra, rb, rc, rd, rzero, zhold;
    logic rdz, zstable;
    int lat, bcnt, t1, t2, ndone;
    longint q_, r_;

    vecs[0] = '{a: 7,    b: 2,  c: 20, d: 4, zero: 1,  z: 5,    dz: 1'b0};
    vecs[1] = '{a: -7,   b: 2,  c: 9,  d: 3, zero: 0,  z: -3,   dz: 1'b0};
    vecs[2] = '{a: -7,   b: 2,  c: 9,  d: 3, zero: -1, z: 3,    dz: 1'b0};
    vecs[3] = '{a: 5,    b: 0,  c: 6,  d: 3, zero: 5,  z: 2,    dz: 1'b1};
    vecs[4] = '{a: 5,    b: 0,  c: 6,  d: 3, zero: 0,  z: -1,   dz: 1'b1};
    vecs[5] = '{a: MINV, b: -1, c: 1,  d: 1, zero: 1,  z: MINV, dz: 1'b0};
    vecs[6] = '{a: MINV, b: -1, c: 1,  d: 1, zero: 0,  z: 1,    dz: 1'b0};
    vecs[7] = '{a: 100,  b: 7,  c: 50, d: 0, zero: 2,  z: -1,   dz: 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_z", z, 0);
    check("reset_dz", dz, 0);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].zero, rz, rdz, lat, bcnt);
      $display("vec %0d: a=%0d b=%0d c=%0d d=%0d zero=%0d -> z=%0d dz=%0b lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].zero, rz, rdz, lat);
      check($sformatf("vec%0d_z", i), rz, vecs[i].z);
      check($sformatf("vec%0d_dz", i), rdz, vecs[i].dz);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, LAT);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_busy_drop", i), busy, 0);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom} >> $urandom_range(0, 62);
        rc = {$urandom, $urandom};
        rd = {$urandom, $urandom} >> $urandom_range(0, 62);
      end else begin
        ra = $signed($urandom_range(0, 80)) - 40;
        rb = $signed($urandom_range(0, 10)) - 5;
        rc = $signed($urandom_range(0, 80)) - 40;
        rd = $signed($urandom_range(0, 6)) - 3;
      end
      if (i == 5) begin ra = MINV; rb = -1; end
      ref_div(ra, rb, q_, r_);
      rzero = (i % 2 == 1) ? r_ : $signed($urandom_range(0, 8)) - 4;
      run_op(ra, rb, rc, rd, rzero, rz, rdz, lat, bcnt);
      $display("rnd %0d: a=%0d b=%0d c=%0d d=%0d zero=%0d -> z=%0d dz=%0b",
               i, ra, rb, rc, rd, rzero, rz, rdz);
      check($sformatf("rnd%0d_z", i), rz, ref_z(ra, rb, rc, rd, rzero));
      check($sformatf("rnd%0d_dz", i), rdz, (rb == 0) || (rd == 0));
      check($sformatf("rnd%0d_latency", i), lat, LAT);
    end

    // start held high: results spaced 2W+5 apart, z stable in between
    @(negedge clk);
    a = -1000; b = 33; c = 77; d = -5; zero = 0; start = 1'b1;
    t1 = -1; t2 = -1; zhold = '0; zstable = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (done) begin
        if (t1 < 0) begin t1 = k; zhold = z; end
        else begin t2 = k; break; end
      end else if (t1 >= 0 && z !== zhold) zstable = 1'b0;
    end
    start = 1'b0;
    $display("hold: first done at %0d, second at %0d, z=%0d", t1, t2, zhold);
    check("hold_z", zhold, ref_z(-1000, 33, 77, -5, 0));
    check("hold_spacing", t2 - t1, LAT + 1);
    check("hold_z_stable", zstable, 1);
    repeat (3) @(negedge clk);

    // start pulsed mid-run with other operands is ignored
    @(negedge clk);
    a = 81; b = -9; c = 12; d = 5; zero = 3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(negedge clk);
    a = 3; b = 1; c = 4; d = 1; zero = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    ndone = 0;
    for (int k = 0; k < 200 && ndone == 0; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    $display("pulse: z=%0d", z);
    check("pulse_done_seen", ndone, 1);
    check("pulse_z", z, ref_z(81, -9, 12, 5, 3));
    ndone = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("pulse_not_queued", ndone, 0);

    // Reset in the middle of an operation
    @(negedge clk);
    a = 55; b = 4; c = 9; d = 2; zero = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b0;
    #1;
    $display("midreset: busy=%0b done=%0b z=%0d dz=%0b", busy, done, z, dz);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_z", z, 0);
    check("midrst_dz", dz, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    check("midrst_z_held", z, 0);
    run_op(-99, 10, 40, -8, -9, rz, rdz, lat, bcnt);
    $display("after reset: z=%0d dz=%0b lat=%0d", rz, rdz, lat);
    check("postrst_z", rz, ref_z(-99, 10, 40, -8, -9));
    check("postrst_latency", lat, LAT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/s5_div_sched.md
# s5_div_sched

Sequencing controller for the s5 datapath. It computes z = (a % b == zero) ? c / d : a / b on one shared iterative signed divider instead of three parallel combinational dividers. The block accepts an operand set on a start strobe and runs the a/b and c/d divisions back to back, each yielding quotient and remainder together. It then performs the equality compare and 2:1 select, and registers z with a done pulse. It sits between the operand source and the downstream consumer of z, replacing the SDIV/SDIV/SMOD/SCOMP/SMUX2x1/SREG chain.

## Interface
- DATAWIDTH, 64, operand and result width (signed, two's complement); legal range 4 and up.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; accepted only when busy=0.
- a, b, c, d, zero  input  DATAWIDTH each  signed operands; sampled only on the accepting edge.
- busy  output  1  high from the cycle after acceptance through the done cycle, inclusive.
- done  output  1  one-cycle pulse; z is valid from this cycle on.
- z  output  DATAWIDTH  signed result; holds until the next done.
- dz  output  1  divide-by-zero flag (b==0 or d==0) for the last result; updates with z.

## Operation
- States: IDLE, DIV_AB, FIX_AB, DIV_CD, FIX_CD, SEL.
- IDLE, start=1: latch a, b, c, d and zero. Load |a| and |b| into the divider and go to DIV_AB.
- DIV_AB: one restoring shift-subtract step per cycle on the unsigned magnitudes. A step counter counts DATAWIDTH steps, after which the state moves to FIX_AB.
- FIX_AB: apply signs and store e and g.
  - e is the quotient, truncated toward zero (negated if sign(a)≠sign(b)).
  - g is the remainder and takes the sign of a.
  - In the same cycle, load |c| and |d|, then go to DIV_CD.
- DIV_CD and FIX_CD: same as above for c/d, producing f. The c/d remainder is discarded.
- SEL: gEQz = (g == zero), compared as a full-width signed value.
  - z <= gEQz ? f : e; dz <= (b==0)|(d==0); done <= 1.
  - Return to IDLE.
- Divide-by-zero (divisor 0): quotient is all ones (-1) and remainder equals the dividend. No trap is raised; the only indication is dz.
- Overflow (dividend = most negative value, divisor = -1): quotient is the most negative value and remainder is 0.
- The magnitude of the most negative value is handled as the unsigned 2^(DATAWIDTH-1), so there is no internal width loss.
- start while busy=1 is ignored: nothing is queued and the latched operands are unchanged.
- Input changes after acceptance have no effect on the operation in flight.

## Timing
- Reset (rst=0, any state, including mid-division): state=IDLE, busy=0, done=0, z=0, dz=0, step counter=0.
  - Internal operand and result registers are also cleared to 0.
  - The first start is accepted on the first rising edge with rst=1.
- The accepting edge is cycle 0. Then:
  - DIV_AB occupies cycles 1..W (W = DATAWIDTH).
  - FIX_AB is cycle W+1; DIV_CD is W+2..2W+1; FIX_CD is 2W+2; SEL is 2W+3.
- done and the new z/dz become visible after the SEL edge, i.e. 2W+4 edges after acceptance (132 for W=64).
  - busy is high for exactly 2W+4 cycles, with done coinciding with its last cycle.
- Back-to-back operation: start is sampled in the cycle done is high.
  - busy is still 1 in that cycle, so that start is ignored.
  - The earliest next acceptance is the cycle after done; throughput is one result per 2W+5 cycles.
- done never stays high for two consecutive cycles. z changes only on the done edge or on reset.

## Test plan
- Reset then basic: a=7, b=2, c=20, d=4, zero=1 → g=1 equals zero → z=5, dz=0. done occurs exactly 132 cycles after acceptance, and busy is high for 132 cycles.
- Signed truncation: a=-7, b=2, c=9, d=3, zero=0 → e=-3, g=-1, gEQz=0 → z=-3. Repeat with zero=-1 → z=3.
- Divide-by-zero: a=5, b=0, c=6, d=3, zero=5 → e=-1, g=5 → z=2, dz=1. Then a=5, b=0, zero=0 → z=-1 (all ones), dz=1.
- Overflow: a=0x8000000000000000, b=-1, c=1, d=1, zero=1 → e=most negative, g=0 → z=0x8000000000000000. The same operands with zero=0 → z=1.
- Protocol: start held high continuously → results are spaced exactly 133 cycles apart, and a start pulsed mid-run is ignored with z unchanged. Operands changed after acceptance do not alter the result.
- Reset mid-operation: assert rst=0 at cycle 50 of a run → busy, done, z and dz go to 0 immediately (asynchronously), and no done appears. A fresh start after release produces the correct result with full latency.
